// File: rtl/target_pkt_pkg.sv
// Shared definitions for the target packet stream: framing constants,
// header word field positions and the parser state encoding.
package target_pkt_pkg;

    localparam logic [31:0] SYNC_WORD     = 32'h1aa11ff1;
    localparam int          HEADER_LENGTH = 4;

    // Header word 2: {reserved[31:17], has_more[16], chunk_length[15:0]}
    localparam int LEN_LSB   = 0;
    localparam int LEN_MSB   = 15;
    localparam int MORE_BIT  = 16;
    localparam int RSVD_LSB  = 17;
    localparam int RSVD_MSB  = 31;

    // Header word 3: {hsize[31:16], vsize[15:0]}
    localparam int HSIZE_LSB = 16;
    localparam int HSIZE_MSB = 31;
    localparam int VSIZE_LSB = 0;
    localparam int VSIZE_MSB = 15;

    typedef enum logic [2:0] {
        S_SYNC,
        S_TS,
        S_LEN,
        S_SIZE,
        S_DATA,
        S_DROP
    } parser_state_t;

endpackage

// File: rtl/target_cell_assembler.sv
// Packs consecutive stream words (least-significant word first) into one
// target record and holds it in a valid/ready output register.
module target_cell_assembler #(
    parameter int DATA_BITS = 32,
    parameter int INFO_BITS = 128
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 flush,
    input  logic                 word_valid,
    input  logic [DATA_BITS-1:0] word_data,
    output logic                 cell_last,
    output logic                 stall,
    output logic [INFO_BITS-1:0] m_info_tdata,
    output logic                 m_info_tvalid,
    input  logic                 m_info_tready
);

    localparam int CELL_LENGTH = INFO_BITS / DATA_BITS;
    localparam int CNT_W       = (CELL_LENGTH > 1) ? $clog2(CELL_LENGTH) : 1;

    logic [CNT_W-1:0]     word_cnt_p0;
    logic [INFO_BITS-1:0] asm_p0;
    logic [INFO_BITS-1:0] rec_nxt;

    assign cell_last = (word_cnt_p0 == CNT_W'(CELL_LENGTH - 1));
    assign stall     = cell_last && m_info_tvalid && !m_info_tready;

    // The final word bypasses the assembly register so the record leaves in one cycle
    always_comb begin
        rec_nxt = asm_p0;
        rec_nxt[(CELL_LENGTH-1)*DATA_BITS +: DATA_BITS] = word_data;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            word_cnt_p0 <= '0;
        end else if (flush) begin
            word_cnt_p0 <= '0;
        end else if (word_valid) begin
            word_cnt_p0 <= cell_last ? '0 : word_cnt_p0 + CNT_W'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (word_valid) begin
            asm_p0[int'(word_cnt_p0)*DATA_BITS +: DATA_BITS] <= word_data;
        end
    end

    // Output stage: record register with valid/ready hand-off
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_info_tdata  <= '0;
            m_info_tvalid <= 1'b0;
        end else if (word_valid && cell_last) begin
            m_info_tdata  <= rec_nxt;
            m_info_tvalid <= 1'b1;
        end else if (m_info_tready) begin
            m_info_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/target_packet_parser.sv
// Receive-side parser for the target packet stream: header FSM, framing checks
// and record reassembly. Optional counters enabled by TARGET_PARSER_STATS_EN.
module target_packet_parser #(
    parameter int          INFO_BITS = 128,
    parameter int          DATA_BITS = 32,
    parameter logic [31:0] SYNC_WORD = 32'h1aa11ff1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [DATA_BITS-1:0] s_tdata,
    input  logic                 s_tvalid,
    input  logic                 s_tlast,
    output logic                 s_tready,
    output logic [INFO_BITS-1:0] m_info_tdata,
    output logic                 m_info_tvalid,
    input  logic                 m_info_tready,
    output logic                 hdr_valid,
    output logic [DATA_BITS-1:0] hdr_timestamp,
    output logic [15:0]          hdr_chunk_length,
    output logic                 hdr_has_more,
    output logic [15:0]          hdr_hsize,
    output logic [15:0]          hdr_vsize,
    output logic                 frame_done,
    output logic                 err_sync,
    output logic                 err_len,
`ifdef TARGET_PARSER_STATS_EN
    input  logic                 stat_clear,
    output logic [31:0]          stat_packets,
    output logic [31:0]          stat_records,
`endif
    output logic [15:0]          err_count
);

    import target_pkt_pkg::*;

    parser_state_t        state, state_nxt;
    logic [DATA_BITS-1:0] ts_q;
    logic [15:0]          len_q;
    logic [15:0]          cells_left;
    logic                 more_q;
    logic                 accept, data_word, flush, final_word;
    logic                 cell_last, cell_stall;
    logic                 hdr_set, clean_set, done_set, sync_set, len_set;

    assign s_tready   = aresetn && !((state == S_DATA) && cell_stall);
    assign accept     = s_tvalid && s_tready;
    assign data_word  = accept && (state == S_DATA);
    assign flush      = (state != S_DATA);
    assign final_word = cell_last && (cells_left == 16'd1);
    assign done_set   = clean_set && !more_q;

    always_comb begin
        state_nxt = state;
        hdr_set   = 1'b0;
        clean_set = 1'b0;
        sync_set  = 1'b0;
        len_set   = 1'b0;
        if (accept) begin
            unique case (state)
                S_SYNC: begin
                    if (s_tdata == SYNC_WORD && !s_tlast) begin
                        state_nxt = S_TS;
                    end else begin
                        sync_set  = 1'b1;
                        state_nxt = s_tlast ? S_SYNC : S_DROP;
                    end
                end
                S_TS: begin
                    len_set   = s_tlast;
                    state_nxt = s_tlast ? S_SYNC : S_LEN;
                end
                S_LEN: begin
                    if (s_tdata[RSVD_MSB:RSVD_LSB] != '0) begin
                        len_set   = 1'b1;
                        state_nxt = s_tlast ? S_SYNC : S_DROP;
                    end else begin
                        len_set   = s_tlast;
                        state_nxt = s_tlast ? S_SYNC : S_SIZE;
                    end
                end
                S_SIZE: begin
                    hdr_set = 1'b1;
                    if (len_q == 16'd0) begin
                        clean_set = s_tlast;
                        len_set   = !s_tlast;
                        state_nxt = s_tlast ? S_SYNC : S_DROP;
                    end else begin
                        len_set   = s_tlast;
                        state_nxt = s_tlast ? S_SYNC : S_DATA;
                    end
                end
                S_DATA: begin
                    if (s_tlast) begin
                        clean_set = final_word;
                        len_set   = !final_word;
                        state_nxt = S_SYNC;
                    end else if (final_word) begin
                        len_set   = 1'b1;
                        state_nxt = S_DROP;
                    end
                end
                S_DROP: begin
                    if (s_tlast) state_nxt = S_SYNC;
                end
                default: state_nxt = S_SYNC;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= S_SYNC;
        else          state <= state_nxt;
    end

    // Header shadow registers; published together when word 3 arrives
    always_ff @(posedge aclk) begin
        if (accept && state == S_TS) ts_q <= s_tdata;
        if (accept && state == S_LEN) begin
            len_q      <= s_tdata[LEN_MSB:LEN_LSB];
            more_q     <= s_tdata[MORE_BIT];
            cells_left <= s_tdata[LEN_MSB:LEN_LSB];
        end else if (data_word && cell_last) begin
            cells_left <= cells_left - 16'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hdr_valid        <= 1'b0;
            hdr_timestamp    <= '0;
            hdr_chunk_length <= '0;
            hdr_has_more     <= 1'b0;
            hdr_hsize        <= '0;
            hdr_vsize        <= '0;
            frame_done       <= 1'b0;
            err_sync         <= 1'b0;
            err_len          <= 1'b0;
            err_count        <= '0;
        end else begin
            hdr_valid  <= hdr_set;
            frame_done <= done_set;
            err_sync   <= sync_set;
            err_len    <= len_set;
            if (hdr_set) begin
                hdr_timestamp    <= ts_q;
                hdr_chunk_length <= len_q;
                hdr_has_more     <= more_q;
                hdr_hsize        <= s_tdata[HSIZE_MSB:HSIZE_LSB];
                hdr_vsize        <= s_tdata[VSIZE_MSB:VSIZE_LSB];
            end
            if ((sync_set || len_set) && err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

    target_cell_assembler #(
        .DATA_BITS(DATA_BITS),
        .INFO_BITS(INFO_BITS)
    ) u_cell (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .flush         (flush),
        .word_valid    (data_word),
        .word_data     (s_tdata),
        .cell_last     (cell_last),
        .stall         (cell_stall),
        .m_info_tdata  (m_info_tdata),
        .m_info_tvalid (m_info_tvalid),
        .m_info_tready (m_info_tready)
    );

`ifdef TARGET_PARSER_STATS_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_packets <= '0;
            stat_records <= '0;
        end else if (stat_clear) begin
            stat_packets <= '0;
            stat_records <= '0;
        end else begin
            if (clean_set)              stat_packets <= stat_packets + 32'd1;
            if (data_word && cell_last) stat_records <= stat_records + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_target_packet_parser.sv
// Directed bench for target_packet_parser with a packet-level reference model.
module tb_target_packet_parser;

    typedef struct packed {
        logic [31:0] ts;
        logic [15:0] len;
        logic        more;
        logic [15:0] hs;
        logic [15:0] vs;
    } hdr_t;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [31:0]  s_tdata = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tlast = 1'b0;
    logic         s_tready;
    logic [127:0] m_info_tdata;
    logic         m_info_tvalid;
    logic         m_info_tready = 1'b1;
    logic         hdr_valid;
    logic [31:0]  hdr_timestamp;
    logic [15:0]  hdr_chunk_length;
    logic         hdr_has_more;
    logic [15:0]  hdr_hsize;
    logic [15:0]  hdr_vsize;
    logic         frame_done;
    logic         err_sync;
    logic         err_len;
    logic [15:0]  err_count;
`ifdef TARGET_PARSER_STATS_EN
    logic         stat_clear = 1'b0;
    logic [31:0]  stat_packets;
    logic [31:0]  stat_records;
`endif

    target_packet_parser dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .s_tdata          (s_tdata),
        .s_tvalid         (s_tvalid),
        .s_tlast          (s_tlast),
        .s_tready         (s_tready),
        .m_info_tdata     (m_info_tdata),
        .m_info_tvalid    (m_info_tvalid),
        .m_info_tready    (m_info_tready),
        .hdr_valid        (hdr_valid),
        .hdr_timestamp    (hdr_timestamp),
        .hdr_chunk_length (hdr_chunk_length),
        .hdr_has_more     (hdr_has_more),
        .hdr_hsize        (hdr_hsize),
        .hdr_vsize        (hdr_vsize),
        .frame_done       (frame_done),
        .err_sync         (err_sync),
        .err_len          (err_len),
`ifdef TARGET_PARSER_STATS_EN
        .stat_clear       (stat_clear),
        .stat_packets     (stat_packets),
        .stat_records     (stat_records),
`endif
        .err_count        (err_count)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_sync = 0, exp_len = 0, exp_done = 0, exp_err = 0;
    int act_sync = 0, act_len = 0, act_done = 0, act_rec = 0;
    int stall_cnt = 0;
    logic [31:0] stall_word = '0;
    logic [31:0] pkt[$];
    logic [127:0] rq[$];
    hdr_t hq[$];

    always @(posedge aclk) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: what a whole packet must produce, from the framing rules alone
    task automatic model_packet();
        int n, len, total, nrec, used;
        logic [127:0] rec;
        hdr_t h;
        n = pkt.size();
        if (pkt[0] != 32'h1aa11ff1 || n == 1) begin
            exp_sync++; exp_err++;
            return;
        end
        if (n < 4 || pkt[2][31:17] != 15'd0) begin
            exp_len++; exp_err++;
            return;
        end
        h.ts = pkt[1]; h.len = pkt[2][15:0]; h.more = pkt[2][16];
        h.hs = pkt[3][31:16]; h.vs = pkt[3][15:0];
        hq.push_back(h);
        len   = int'(pkt[2][15:0]);
        total = 4 + 4 * len;
        used  = (n < total) ? n : total;
        nrec  = (used - 4) / 4;
        for (int k = 0; k < nrec; k++) begin
            rec = {pkt[4+4*k+3], pkt[4+4*k+2], pkt[4+4*k+1], pkt[4+4*k]};
            rq.push_back(rec);
        end
        if (n == total) begin
            if (!pkt[2][16]) exp_done++;
        end else begin
            exp_len++; exp_err++;
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        logic ok;
        int guard;
        s_tdata = d; s_tvalid = 1'b1; s_tlast = last;
        ok = 1'b0; guard = 0;
        while (!ok && guard < 200) begin
            #1 ok = s_tready;
            @(negedge aclk);
            guard++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=stalled required=accepted word=%0h", d);
        end
    endtask

    task automatic send_packet(input logic with_tlast);
        for (int i = 0; i < pkt.size(); i++) begin
            send_word(pkt[i], with_tlast && (i == pkt.size() - 1));
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic build(input logic [31:0] ts, input logic [31:0] lw, input logic [31:0] sz, input int ndata);
        pkt = {32'h1aa11ff1, ts, lw, sz};
        for (int i = 1; i <= ndata; i++) pkt.push_back(32'(i));
    endtask

    task automatic settle_and_check(input string tag);
        repeat (5) @(negedge aclk);
        chk({tag, "_err_sync"}, 128'(act_sync), 128'(exp_sync));
        chk({tag, "_err_len"}, 128'(act_len), 128'(exp_len));
        chk({tag, "_frame_done"}, 128'(act_done), 128'(exp_done));
        chk({tag, "_err_count"}, 128'(err_count), 128'(exp_err));
        chk({tag, "_rec_left"}, 128'(rq.size()), 128'd0);
        chk({tag, "_hdr_left"}, 128'(hq.size()), 128'd0);
    endtask

    // Single compare process, sampled mid-cycle
    always @(negedge aclk) begin
        #2;
        if (aresetn) begin
            if (s_tvalid && !s_tready) begin
                stall_cnt++;
                stall_word = s_tdata;
            end
            if (err_sync || err_len) chk("err_exclusive", 128'(err_sync && err_len), 128'd0);
            if (err_sync) act_sync++;
            if (err_len) act_len++;
            if (frame_done) act_done++;
            if (m_info_tvalid && m_info_tready) begin
                act_rec++;
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rec_unexpected actual=%0h required=none", m_info_tdata);
                end else begin
                    chk("record", m_info_tdata, rq.pop_front());
                end
            end
            if (hdr_valid) begin
                if (hq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL hdr_unexpected actual=%0h required=none", hdr_timestamp);
                end else begin
                    hdr_t h;
                    h = hq.pop_front();
                    chk("hdr_timestamp", 128'(hdr_timestamp), 128'(h.ts));
                    chk("hdr_chunk_length", 128'(hdr_chunk_length), 128'(h.len));
                    chk("hdr_has_more", 128'(hdr_has_more), 128'(h.more));
                    chk("hdr_hsize", 128'(hdr_hsize), 128'(h.hs));
                    chk("hdr_vsize", 128'(hdr_vsize), 128'(h.vs));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, s0, r0, d0;

        #1 chk("reset_s_tready", 128'(s_tready), 128'd0);
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        #1;
        chk("reset_m_info_tvalid", 128'(m_info_tvalid), 128'd0);
        chk("reset_m_info_tdata", m_info_tdata, 128'd0);
        chk("reset_hdr", 128'({hdr_valid, hdr_timestamp, hdr_chunk_length, hdr_has_more, hdr_hsize, hdr_vsize}), 128'd0);
        chk("reset_pulses", 128'({frame_done, err_sync, err_len}), 128'd0);
        chk("reset_err_count", 128'(err_count), 128'd0);
        chk("idle_s_tready", 128'(s_tready), 128'd1);
        @(negedge aclk);

        // Header-only packet
        build(32'h12345678, 32'h00000000, 32'h02800168, 0);
        model_packet();
        chk("model_hsize", 128'(hq[0].hs), 128'd640);
        chk("model_vsize", 128'(hq[0].vs), 128'd360);
        r0 = act_rec;
        send_packet(1'b1);
        settle_and_check("hdr_only");
        chk("hdr_only_no_records", 128'(act_rec - r0), 128'd0);
        chk("hdr_hold_hsize", 128'(hdr_hsize), 128'd640);

        // Two cells, full rate
        build(32'hCAFE0001, 32'h00010002, 32'h00100020, 8);
        model_packet();
        chk("model_rec0", rq[0], 128'h00000004_00000003_00000002_00000001);
        chk("model_rec1", rq[1], 128'h00000008_00000007_00000006_00000005);
        c0 = cyc;
        send_packet(1'b1);
        chk("full_rate_cycles", 128'(cyc - c0), 128'd12);
        settle_and_check("two_cells");

        // Back-pressure on the final word
        build(32'hCAFE0002, 32'h00010002, 32'h00100020, 8);
        model_packet();
        s0 = stall_cnt;
        fork
            begin
                m_info_tready = 1'b0;
                repeat (14) @(negedge aclk);
                m_info_tready = 1'b1;
            end
            send_packet(1'b1);
        join
        chk("bp_stalled", 128'(stall_cnt > s0), 128'd1);
        chk("bp_stall_word", 128'(stall_word), 128'd8);
        settle_and_check("backpressure");

        // Bad sync, then a valid packet
        pkt = {32'hDEADBEEF, 32'h1aa11ff1, 32'h11111111, 32'h00000001, 32'h22222222, 32'h33333333};
        model_packet();
        send_packet(1'b1);
        build(32'hCAFE0003, 32'h00000002, 32'h00400030, 8);
        model_packet();
        send_packet(1'b1);
        settle_and_check("bad_sync");

        // Early tlast on data word 6
        build(32'hCAFE0004, 32'h00000002, 32'h00010001, 6);
        model_packet();
        send_packet(1'b1);
        settle_and_check("early_tlast");

        // Missing tlast on final word, two trailing words dropped
        build(32'hCAFE0005, 32'h00000001, 32'h00020002, 4);
        pkt.push_back(32'hAAAA0001);
        pkt.push_back(32'hAAAA0002);
        model_packet();
        send_packet(1'b1);
        settle_and_check("missing_tlast");

        // Reset in the middle of S_DATA with a record held
        build(32'h0BADF00D, 32'h00000002, 32'h00100010, 5);
        hq.push_back(hdr_t'({32'h0BADF00D, 16'd2, 1'b0, 16'h0010, 16'h0010}));
        m_info_tready = 1'b0;
        send_packet(1'b0);
        aresetn = 1'b0;
        #1;
        chk("midrst_m_info_tvalid", 128'(m_info_tvalid), 128'd0);
        chk("midrst_m_info_tdata", m_info_tdata, 128'd0);
        chk("midrst_hdr", 128'({hdr_valid, hdr_timestamp, hdr_chunk_length, hdr_hsize, hdr_vsize}), 128'd0);
        chk("midrst_err_count", 128'(err_count), 128'd0);
        chk("midrst_s_tready", 128'(s_tready), 128'd0);
        exp_err = 0;
        @(negedge aclk);
        aresetn = 1'b1;
        m_info_tready = 1'b1;
        @(negedge aclk);
        d0 = act_done;
        build(32'h12345678, 32'h00000000, 32'h02800168, 0);
        model_packet();
        send_packet(1'b1);
        settle_and_check("restart");
        chk("restart_frame_done", 128'(act_done - d0), 128'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
